// File: rtl/cc_pkg.sv
// Shared constants and FSM state type for the code-calculator sequencer slice.
package cc_pkg;

  localparam int DATA_W = 4;
  localparam int OPT_W  = 3;
  localparam int OUT_W  = 10;
  localparam int N_OPND = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } cc_state_t;

endpackage

// File: rtl/cc_seq_ctrl_if.sv
// Host-side serial job interface: operand burst in, result and error pulses out.
interface cc_seq_ctrl_if #(
  parameter int DATA_W = cc_pkg::DATA_W,
  parameter int OPT_W  = cc_pkg::OPT_W,
  parameter int OUT_W  = cc_pkg::OUT_W
);
  import cc_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [OPT_W-1:0]  in_opt;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              err;

  // Host drives the burst and collects the result.
  modport master (
    output in_valid, in_data, in_opt,
    input  out_valid, out_data, err
  );

  // Sequencer consumes the burst and returns the result.
  modport slave (
    input  in_valid, in_data, in_opt,
    output out_valid, out_data, err
  );

endinterface

// File: rtl/cc_operand_bank.sv
// Five-entry operand register file plus option register feeding the CC core.
module cc_operand_bank #(
  parameter int DATA_W = cc_pkg::DATA_W,
  parameter int OPT_W  = cc_pkg::OPT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              opt_wr,
  input  logic [OPT_W-1:0]  opt_data,
  output logic [OPT_W-1:0]  cc_opt,
  output logic [DATA_W-1:0] cc_n0,
  output logic [DATA_W-1:0] cc_n1,
  output logic [DATA_W-1:0] cc_n2,
  output logic [DATA_W-1:0] cc_n3,
  output logic [DATA_W-1:0] cc_n4
);
  import cc_pkg::*;

  logic [DATA_W-1:0] opnd_q [N_OPND];
  logic [OPT_W-1:0]  opt_q;

  // Store one operand beat at wr_idx, and the option on the first beat only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OPND; i++) opnd_q[i] <= '0;
      opt_q <= '0;
    end else begin
      if (opt_wr) opt_q <= opt_data;
      for (int i = 0; i < N_OPND; i++) begin
        if (wr_en && (wr_idx == 3'(i))) opnd_q[i] <= wr_data;
      end
    end
  end

  assign cc_opt = opt_q;
  assign cc_n0  = opnd_q[0];
  assign cc_n1  = opnd_q[1];
  assign cc_n2  = opnd_q[2];
  assign cc_n3  = opnd_q[3];
  assign cc_n4  = opnd_q[4];

endmodule

// File: rtl/cc_seq_ctrl.sv
// Sequencer around the combinational code calculator: collects a 5-beat
// operand burst, lets CC settle, then returns its result as a one-cycle pulse.
module cc_seq_ctrl #(
  parameter int DATA_W     = cc_pkg::DATA_W,
  parameter int OPT_W      = cc_pkg::OPT_W,
  parameter int OUT_W      = cc_pkg::OUT_W,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  cc_seq_ctrl_if.slave      host,
  output logic [OPT_W-1:0]  cc_opt,
  output logic [DATA_W-1:0] cc_n0,
  output logic [DATA_W-1:0] cc_n1,
  output logic [DATA_W-1:0] cc_n2,
  output logic [DATA_W-1:0] cc_n3,
  output logic [DATA_W-1:0] cc_n4,
  input  logic [OUT_W-1:0]  cc_out
);
  import cc_pkg::*;

  cc_state_t        state;
  logic [2:0]       beat;
  logic [3:0]       settle;
  logic             out_valid_q;
  logic [OUT_W-1:0] result_q;
  logic             err_q;

  logic             bank_wr;
  logic [2:0]       bank_idx;
  logic             opt_wr;

  // Operand writes happen only while a burst is being accepted; IDLE takes beat 0.
  assign bank_wr  = host.in_valid && ((state == IDLE) || (state == LOAD));
  assign bank_idx = (state == IDLE) ? 3'd0 : beat;
  assign opt_wr   = host.in_valid && (state == IDLE);

  cc_operand_bank #(
    .DATA_W (DATA_W),
    .OPT_W  (OPT_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bank_wr),
    .wr_idx   (bank_idx),
    .wr_data  (host.in_data),
    .opt_wr   (opt_wr),
    .opt_data (host.in_opt),
    .cc_opt   (cc_opt),
    .cc_n0    (cc_n0),
    .cc_n1    (cc_n1),
    .cc_n2    (cc_n2),
    .cc_n3    (cc_n3),
    .cc_n4    (cc_n4)
  );

  // Job FSM with registered pulses; result_q is held non-zero only in the OUT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      settle      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (host.in_valid) begin
            beat  <= 3'd1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (host.in_valid) begin
            if (beat == 3'(N_OPND - 1)) begin
              beat   <= '0;
              settle <= '0;
              state  <= SETTLE;
            end else begin
              beat <= beat + 3'd1;
            end
          end else begin
            err_q <= 1'b1;
            beat  <= '0;
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (host.in_valid) err_q <= 1'b1;
          if (settle == 4'(SETTLE_CYC - 1)) begin
            out_valid_q <= 1'b1;
            result_q    <= cc_out;
            settle      <= '0;
            state       <= OUT;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        OUT: begin
          if (host.in_valid) err_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.out_valid = out_valid_q;
  assign host.out_data  = result_q;
  assign host.err       = err_q;

endmodule

// File: tb/tb_cc_seq_ctrl.sv
// Directed bench for cc_seq_ctrl with a stub CC (sum of operands + opt<<7).
module tb_cc_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  cc_seq_ctrl_if bus_a ();
  cc_seq_ctrl_if bus_b ();

  logic [2:0] a_opt, b_opt;
  logic [3:0] a_n0, a_n1, a_n2, a_n3, a_n4;
  logic [3:0] b_n0, b_n1, b_n2, b_n3, b_n4;
  logic [9:0] a_out, b_out;

  // Stub CC cores
  assign a_out = 10'(a_n0) + 10'(a_n1) + 10'(a_n2) + 10'(a_n3) + 10'(a_n4) + (10'(a_opt) << 7);
  assign b_out = 10'(b_n0) + 10'(b_n1) + 10'(b_n2) + 10'(b_n3) + 10'(b_n4) + (10'(b_opt) << 7);

  cc_seq_ctrl #(.SETTLE_CYC(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .host (bus_a),
    .cc_opt (a_opt), .cc_n0 (a_n0), .cc_n1 (a_n1), .cc_n2 (a_n2),
    .cc_n3 (a_n3), .cc_n4 (a_n4), .cc_out (a_out)
  );

  cc_seq_ctrl #(.SETTLE_CYC(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .host (bus_b),
    .cc_opt (b_opt), .cc_n0 (b_n0), .cc_n1 (b_n1), .cc_n2 (b_n2),
    .cc_n3 (b_n3), .cc_n4 (b_n4), .cc_out (b_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive n beats (low nibble first) on bus a (sel=0) or bus b (sel=1); in_valid drops after.
  task automatic feed(input bit sel, input logic [2:0] opt, input logic [19:0] beats,
                      input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (sel) begin
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = beats[4*k +: 4];
        bus_b.in_opt   = (k == 0) ? opt : 3'd0;
      end else begin
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = beats[4*k +: 4];
        bus_a.in_opt   = (k == 0) ? opt : 3'd0;
      end
      tick();
      check({tag, " err during burst"}, 32'(sel ? bus_b.err : bus_a.err), 32'd0);
    end
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_opt = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_opt = '0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_opt = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_opt = '0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    check("rst out_valid", 32'(bus_a.out_valid), 0);
    check("rst out_data", 32'(bus_a.out_data), 0);
    check("rst err", 32'(bus_a.err), 0);
    check("rst cc_opt", 32'(a_opt), 0);
    check("rst cc_n0", 32'(a_n0), 0);
    check("rst cc_n4", 32'(a_n4), 0);
    check("rst b out_valid", 32'(bus_b.out_valid), 0);
    rst_n = 1'b1;
    tick();

    // Nominal job: opt 2, beats 1..5 -> 271 two cycles after beat 4
    feed(0, 3'd2, 20'h54321, 5, "nom");
    check("nom cc_opt", 32'(a_opt), 2);
    check("nom cc_n0", 32'(a_n0), 1);
    check("nom cc_n4", 32'(a_n4), 5);
    check("nom early out_valid", 32'(bus_a.out_valid), 0);
    check("nom early out_data", 32'(bus_a.out_data), 0);
    tick();
    check("nom out_valid", 32'(bus_a.out_valid), 1);
    check("nom out_data", 32'(bus_a.out_data), 271);
    check("nom err", 32'(bus_a.err), 0);
    tick();
    check("nom after out_valid", 32'(bus_a.out_valid), 0);
    check("nom after out_data", 32'(bus_a.out_data), 0);

    // Extremes: all ones, then all zeros
    feed(0, 3'd7, 20'hFFFFF, 5, "max");
    tick();
    check("max out_valid", 32'(bus_a.out_valid), 1);
    check("max out_data", 32'(bus_a.out_data), 971);
    tick();
    feed(0, 3'd0, 20'h00000, 5, "zero");
    tick();
    check("zero out_valid", 32'(bus_a.out_valid), 1);
    check("zero out_data", 32'(bus_a.out_data), 0);
    tick();

    // Abort after 3 beats, then a full job
    feed(0, 3'd4, 20'h00777, 3, "abort");
    tick();
    check("abort err", 32'(bus_a.err), 1);
    check("abort out_valid", 32'(bus_a.out_valid), 0);
    check("abort cc_n3 kept", 32'(a_n3), 0);
    tick();
    check("abort err cleared", 32'(bus_a.err), 0);
    check("abort no out_valid", 32'(bus_a.out_valid), 0);
    feed(0, 3'd1, 20'h11111, 5, "post-abort");
    tick();
    check("post-abort out_valid", 32'(bus_a.out_valid), 1);
    check("post-abort out_data", 32'(bus_a.out_data), 133);
    tick();

    // Busy violation during SETTLE on the SETTLE_CYC=4 instance
    feed(1, 3'd2, 20'h54321, 5, "busy");
    tick();
    bus_b.in_valid = 1'b1; bus_b.in_data = 4'hF;
    tick();
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    check("busy err", 32'(bus_b.err), 1);
    check("busy early out_valid", 32'(bus_b.out_valid), 0);
    tick();
    check("busy err cleared", 32'(bus_b.err), 0);
    check("busy t+4 out_valid", 32'(bus_b.out_valid), 0);
    tick();
    check("busy t+5 out_valid", 32'(bus_b.out_valid), 1);
    check("busy out_data", 32'(bus_b.out_data), 271);
    check("busy data ignored", 32'(b_n0), 1);
    tick();

    // Reset in the middle of LOAD
    feed(0, 3'd3, 20'h00099, 2, "rstload");
    rst_n = 1'b0;
    tick();
    check("rstload out_valid", 32'(bus_a.out_valid), 0);
    check("rstload out_data", 32'(bus_a.out_data), 0);
    check("rstload err", 32'(bus_a.err), 0);
    check("rstload cc_opt", 32'(a_opt), 0);
    check("rstload cc_n0", 32'(a_n0), 0);
    check("rstload cc_n1", 32'(a_n1), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("rstload no out_valid", 32'(bus_a.out_valid), 0);
    check("rstload no err", 32'(bus_a.err), 0);
    feed(0, 3'd0, 20'h22222, 5, "post-rst");
    tick();
    check("post-rst out_valid", 32'(bus_a.out_valid), 1);
    check("post-rst out_data", 32'(bus_a.out_data), 10);
    tick();

    // Back-to-back: second job starts the cycle after OUT
    feed(0, 3'd2, 20'h54321, 5, "b2b1");
    tick();
    check("b2b1 out_data", 32'(bus_a.out_data), 271);
    tick();
    feed(0, 3'd3, 20'h65432, 5, "b2b2");
    tick();
    check("b2b2 out_valid", 32'(bus_a.out_valid), 1);
    check("b2b2 out_data", 32'(bus_a.out_data), 404);
    check("b2b2 err", 32'(bus_a.err), 0);
    tick();

    // Start asserted in the OUT cycle is a violation
    feed(0, 3'd0, 20'h11111, 5, "b2b3");
    tick();
    check("b2b3 out_data", 32'(bus_a.out_data), 5);
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'h9;
    tick();
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    check("early start err", 32'(bus_a.err), 1);
    check("early start out_valid", 32'(bus_a.out_valid), 0);
    tick(); tick(); tick();
    check("early start no job", 32'(bus_a.out_valid), 0);
    check("early start err cleared", 32'(bus_a.err), 0);
    check("early start not stored", 32'(a_n0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
